ann_argmax: RTL

//  Downstream classifier stage for the ann core. On the core's done pulse it reads every result word

---
 rtl/ann_pkg.sv | 33 +++
 rtl/ann_argmax_if.sv | 31 +++
 rtl/ann_argmax_cmp.sv | 30 +++
 rtl/ann_argmax.sv | 119 +++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared constants, state encoding and lane helper
// for the ann argmax classifier stage.
package ann_pkg;

  localparam int NUM_SAMPLES = 4;
  localparam int NUM_CLASSES = 4;
  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 10;
  localparam int ADDR_W      = 2;
  localparam int IDX_W       = 2;
  localparam int WORD_W      = NUM_CLASSES * DATA_W;

  typedef logic [WORD_W-1:0]        word_t;
  typedef logic signed [DATA_W-1:0] score_t;
  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  localparam idx_t LAST_LANE   = idx_t'(NUM_CLASSES - 1);
  localparam idx_t LAST_SAMPLE = idx_t'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_CMP,
    S_OUT
  } state_t;

  function automatic score_t lane(word_t w, idx_t i);
    return score_t'(w[DATA_W*int'(i) +: DATA_W]);
  endfunction

endpackage

// File: rtl/ann_argmax_if.sv
// Result stream of the argmax stage:
// one class/score per sample, valid/ready.
interface ann_argmax_if;
  import ann_pkg::*;

  logic   m_valid;
  logic   m_ready;
  idx_t   m_sample;
  idx_t   m_class;
  score_t m_score;
  logic   m_last;

  modport master (
    output m_valid,
    input  m_ready,
    output m_sample,
    output m_class,
    output m_score,
    output m_last
  );

  modport slave (
    input  m_valid,
    output m_ready,
    input  m_sample,
    input  m_class,
    input  m_score,
    input  m_last
  );

endinterface

// File: rtl/ann_argmax_cmp.sv
// Running maximum over one lane per cycle;
// strict compare keeps the lowest index on ties.
module ann_argmax_cmp
  import ann_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   init,
  input  logic   en,
  input  score_t val,
  input  idx_t   idx,
  output score_t best,
  output idx_t   best_idx
);

  // seed with lane 0, then take any strictly larger lane
  always_ff @(posedge clk) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
    end else if (init) begin
      best     <= val;
      best_idx <= idx;
    end else if (en && (val > best)) begin
      best     <= val;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/ann_argmax.sv
// Argmax classifier: scans every activation word
// after ann done and streams one class per sample.
module ann_argmax
  import ann_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         overrun,
  output logic         a_enb,
  output addr_t        a_addrb,
  input  word_t        a_doutb,
  ann_argmax_if.master res
);

  state_t state;
  idx_t   sample_cnt;
  idx_t   lane_cnt;
  word_t  word_q;

  logic   cmp_init;
  logic   cmp_en;
  score_t cmp_val;
  idx_t   cmp_idx;
  score_t best;
  idx_t   best_idx;

  assign cmp_init = (state == S_WT);
  assign cmp_en   = (state == S_CMP);
  assign cmp_val  = cmp_init ? lane(a_doutb, '0)
                             : lane(word_q, lane_cnt);
  assign cmp_idx  = cmp_init ? '0 : lane_cnt;

  ann_argmax_cmp u_cmp (
    .clk      (clk),
    .rst      (rst),
    .init     (cmp_init),
    .en       (cmp_en),
    .val      (cmp_val),
    .idx      (cmp_idx),
    .best     (best),
    .best_idx (best_idx)
  );

  // best/best_idx only move in WT/CMP,
  // so they are stable while OUT waits
  assign res.m_sample = sample_cnt;
  assign res.m_class  = best_idx;
  assign res.m_score  = best;

  // run sequencer with registered BRAM and
  // result-stream controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      a_enb       <= 1'b0;
      a_addrb     <= '0;
      res.m_valid <= 1'b0;
      res.m_last  <= 1'b0;
      sample_cnt  <= '0;
      lane_cnt    <= '0;
      word_q      <= '0;
    end else begin
      a_enb <= 1'b0;
      if (start && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RD;
            busy    <= 1'b1;
            a_enb   <= 1'b1;
            a_addrb <= addr_t'(sample_cnt);
          end
        end
        S_RD: begin
          state <= S_WT;
        end
        S_WT: begin
          word_q   <= a_doutb;
          lane_cnt <= idx_t'(1);
          state    <= S_CMP;
        end
        S_CMP: begin
          lane_cnt <= lane_cnt + idx_t'(1);
          if (lane_cnt == LAST_LANE) begin
            state       <= S_OUT;
            res.m_valid <= 1'b1;
            res.m_last  <= (sample_cnt == LAST_SAMPLE);
          end
        end
        S_OUT: begin
          if (res.m_ready) begin
            res.m_valid <= 1'b0;
            res.m_last  <= 1'b0;
            if (res.m_last) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              sample_cnt <= '0;
            end else begin
              state      <= S_RD;
              sample_cnt <= sample_cnt + idx_t'(1);
              a_enb      <= 1'b1;
              a_addrb    <= addr_t'(sample_cnt + idx_t'(1));
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
